// File: rtl/axi_mem_pkg.sv
// Shared encodings for the AXI SRAM slave: burst types, response codes and
// the read/write FSM state enums.
package axi_mem_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_e;

    typedef enum logic {
        R_IDLE,
        R_BURST
    } r_state_e;

endpackage

// File: rtl/axi_burst_addr.sv
// Per-channel AXI beat address generator: captures the burst descriptor on
// load and steps FIXED / INCR / WRAP addresses on each advance.
module axi_burst_addr
    import axi_mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              load,
    input  logic              advance,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [7:0]        len,
    input  logic [2:0]        size,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] addr
);

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] wrap_mask;
    logic [ADDR_W-1:0] incr;
    logic [ADDR_W-1:0] addr_nx;
    logic [7:0]        len_q;
    logic [2:0]        size_q;
    burst_e            burst_q;

    always_comb begin
        step      = ADDR_W'(1) << size_q;
        // Wrap block is (len+1)*step bytes; legal WRAP lengths make this a power of two.
        wrap_mask = ((ADDR_W'(len_q) + ADDR_W'(1)) << size_q) - ADDR_W'(1);
        incr      = addr_q + step;
        case (burst_q)
            BURST_FIXED: addr_nx = addr_q;
            BURST_WRAP:  addr_nx = (addr_q & ~wrap_mask) | (incr & wrap_mask);
            default:     addr_nx = incr;
        endcase
    end

    always_ff @(posedge clock) begin
        if (load) begin
            addr_q  <= start_addr;
            len_q   <= len;
            size_q  <= size;
            burst_q <= burst_e'(burst);
        end else if (advance) begin
            addr_q  <= addr_nx;
        end
    end

    assign addr = addr_q;

endmodule

// File: rtl/axi_sram_mem.sv
// AXI4 slave over a dual-port word SRAM with independent read and write FSMs.
// Define AXI_SRAM_MEM_DECERR_EN to flag out-of-range beats with DECERR.
module axi_sram_mem
    import axi_mem_pkg::*;
#(
    parameter int                DATA_W    = 64,
    parameter int                ID_W      = 4,
    parameter int                ADDR_W    = 32,
    parameter int                DEPTH     = 4096,
    parameter logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(32'h7fff_ffff)
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                io_axi4_0_aw_valid,
    input  logic [ID_W-1:0]     io_axi4_0_aw_id,
    input  logic [ADDR_W-1:0]   io_axi4_0_aw_addr,
    input  logic [7:0]          io_axi4_0_aw_len,
    input  logic [2:0]          io_axi4_0_aw_size,
    input  logic [1:0]          io_axi4_0_aw_burst,
    output logic                io_axi4_0_aw_ready,
    input  logic                io_axi4_0_w_valid,
    input  logic [DATA_W-1:0]   io_axi4_0_w_data,
    input  logic [DATA_W/8-1:0] io_axi4_0_w_strb,
    input  logic                io_axi4_0_w_last,
    output logic                io_axi4_0_w_ready,
    input  logic                io_axi4_0_b_ready,
    output logic                io_axi4_0_b_valid,
    output logic [ID_W-1:0]     io_axi4_0_b_id,
    output logic [1:0]          io_axi4_0_b_resp,
    input  logic                io_axi4_0_ar_valid,
    input  logic [ID_W-1:0]     io_axi4_0_ar_id,
    input  logic [ADDR_W-1:0]   io_axi4_0_ar_addr,
    input  logic [7:0]          io_axi4_0_ar_len,
    input  logic [2:0]          io_axi4_0_ar_size,
    input  logic [1:0]          io_axi4_0_ar_burst,
    output logic                io_axi4_0_ar_ready,
    input  logic                io_axi4_0_r_ready,
    output logic                io_axi4_0_r_valid,
    output logic [ID_W-1:0]     io_axi4_0_r_id,
    output logic [DATA_W-1:0]   io_axi4_0_r_data,
    output logic [1:0]          io_axi4_0_r_resp,
    output logic                io_axi4_0_r_last
);

    localparam int STRB_W  = DATA_W / 8;
    localparam int BYTE_SH = $clog2(STRB_W);
    localparam int IDX_W   = $clog2(DEPTH);
`ifdef AXI_SRAM_MEM_DECERR_EN
    localparam bit DECERR_EN = 1'b1;
`else
    localparam bit DECERR_EN = 1'b0;
`endif

    function automatic logic [ADDR_W-1:0] word_pos(input logic [ADDR_W-1:0] a);
        return (a & ADDR_MASK) >> BYTE_SH;
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    w_state_e          w_state, w_state_nx;
    logic [ADDR_W-1:0] w_addr, w_pos;
    logic [IDX_W-1:0]  w_idx;
    logic              w_oor, w_in_len, aw_hs, w_hs, wr_en;
    logic [8:0]        w_cnt;
    logic [7:0]        w_len_q;
    logic [ID_W-1:0]   b_id_q;
    logic              b_err;

    assign aw_hs    = io_axi4_0_aw_valid && io_axi4_0_aw_ready;
    assign w_hs     = io_axi4_0_w_valid && io_axi4_0_w_ready;
    assign w_pos    = word_pos(w_addr);
    assign w_idx    = w_pos[IDX_W-1:0];
    assign w_oor    = DECERR_EN && (w_pos >= ADDR_W'(DEPTH));
    assign w_in_len = (w_cnt <= {1'b0, w_len_q});
    assign wr_en    = w_hs && w_in_len && !w_oor;

    axi_burst_addr #(.ADDR_W(ADDR_W)) u_w_addr (
        .clock      (clock),
        .load       (aw_hs),
        .advance    (w_hs),
        .start_addr (io_axi4_0_aw_addr),
        .len        (io_axi4_0_aw_len),
        .size       (io_axi4_0_aw_size),
        .burst      (io_axi4_0_aw_burst),
        .addr       (w_addr)
    );

    always_comb begin
        w_state_nx         = w_state;
        io_axi4_0_aw_ready = 1'b0;
        io_axi4_0_w_ready  = 1'b0;
        io_axi4_0_b_valid  = 1'b0;
        case (w_state)
            W_IDLE: begin
                io_axi4_0_aw_ready = 1'b1;
                if (io_axi4_0_aw_valid) w_state_nx = W_DATA;
            end
            W_DATA: begin
                io_axi4_0_w_ready = 1'b1;
                if (io_axi4_0_w_valid && io_axi4_0_w_last) w_state_nx = W_RESP;
            end
            W_RESP: begin
                io_axi4_0_b_valid = 1'b1;
                if (io_axi4_0_b_ready) w_state_nx = W_IDLE;
            end
            default: w_state_nx = W_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            w_state <= W_IDLE;
            w_cnt   <= '0;
            w_len_q <= '0;
            b_id_q  <= '0;
            b_err   <= 1'b0;
        end else begin
            w_state <= w_state_nx;
            if (aw_hs) begin
                w_cnt   <= '0;
                w_len_q <= io_axi4_0_aw_len;
                b_id_q  <= io_axi4_0_aw_id;
                b_err   <= 1'b0;
            end else if (w_hs) begin
                // Saturate so surplus beats past len+1 can never alias back into range.
                if (w_cnt != '1) w_cnt <= w_cnt + 9'd1;
                if (w_in_len && w_oor) b_err <= 1'b1;
            end
        end
    end

    assign io_axi4_0_b_id   = b_id_q;
    assign io_axi4_0_b_resp = b_err ? RESP_DECERR : RESP_OKAY;

    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (io_axi4_0_w_strb[b]) mem[w_idx][b*8 +: 8] <= io_axi4_0_w_data[b*8 +: 8];
            end
        end
    end

    r_state_e          r_state, r_state_nx;
    logic [ADDR_W-1:0] r_addr, r_pos;
    logic [IDX_W-1:0]  r_idx;
    logic              r_oor, ar_hs, adv, issue;
    logic [8:0]        r_left;
    logic [ID_W-1:0]   r_id_q;
    logic              vld_p0, last_p0, vld_p1, last_p1;
    logic [1:0]        resp_p0, resp_p1;
    logic [DATA_W-1:0] data_p0, data_p1;

    assign ar_hs = io_axi4_0_ar_valid && io_axi4_0_ar_ready;
    assign r_pos = word_pos(r_addr);
    assign r_idx = r_pos[IDX_W-1:0];
    assign r_oor = DECERR_EN && (r_pos >= ADDR_W'(DEPTH));
    // Whole pipeline stalls together while the output beat is held.
    assign adv   = !vld_p1 || io_axi4_0_r_ready;
    assign issue = (r_state == R_BURST) && (r_left != '0) && adv;

    axi_burst_addr #(.ADDR_W(ADDR_W)) u_r_addr (
        .clock      (clock),
        .load       (ar_hs),
        .advance    (issue),
        .start_addr (io_axi4_0_ar_addr),
        .len        (io_axi4_0_ar_len),
        .size       (io_axi4_0_ar_size),
        .burst      (io_axi4_0_ar_burst),
        .addr       (r_addr)
    );

    always_comb begin
        r_state_nx         = r_state;
        io_axi4_0_ar_ready = 1'b0;
        case (r_state)
            R_IDLE: begin
                io_axi4_0_ar_ready = 1'b1;
                if (io_axi4_0_ar_valid) r_state_nx = R_BURST;
            end
            R_BURST: begin
                if (vld_p1 && io_axi4_0_r_ready && last_p1) r_state_nx = R_IDLE;
            end
            default: r_state_nx = R_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= R_IDLE;
            r_left  <= '0;
            r_id_q  <= '0;
            vld_p0  <= 1'b0;
            last_p0 <= 1'b0;
            resp_p0 <= RESP_OKAY;
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
            resp_p1 <= RESP_OKAY;
        end else begin
            r_state <= r_state_nx;
            if (ar_hs) begin
                r_left <= 9'(io_axi4_0_ar_len) + 9'd1;
                r_id_q <= io_axi4_0_ar_id;
            end else if (issue) begin
                r_left <= r_left - 9'd1;
            end
            if (adv) begin
                // p0: memory read issued
                vld_p0  <= issue;
                last_p0 <= issue && (r_left == 9'd1);
                resp_p0 <= (issue && r_oor) ? RESP_DECERR : RESP_OKAY;
                // p1: beat presented on R
                vld_p1  <= vld_p0;
                last_p1 <= last_p0;
                resp_p1 <= resp_p0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (adv) begin
            if (issue) data_p0 <= r_oor ? '0 : mem[r_idx];
            data_p1 <= data_p0;
        end
    end

    assign io_axi4_0_r_valid = vld_p1;
    assign io_axi4_0_r_last  = last_p1;
    assign io_axi4_0_r_resp  = resp_p1;
    assign io_axi4_0_r_data  = data_p1;
    assign io_axi4_0_r_id    = r_id_q;

endmodule

// File: doc/axi_sram_mem.md
AXI_SRAM_MEM -- requirements
Module: axi_sram_mem

Interface
REQ-001 The block SHALL take these parameters, one per line:
- DATA_W, 64, AXI data width in bits; 32, 64 or 128.
- ID_W, 4, AXI ID width.
- ADDR_W, 32, AXI address width.
- DEPTH, 4096, memory depth in DATA_W words; power of two.
- ADDR_MASK, 32'h7fff_ffff, AND-mask applied to AR/AW addresses before decode.

REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.

REQ-003 Ports SHALL be as follows, clock and reset first (name, direction, width, meaning):
- clock, in, 1, sole clock.
- resetn, in, 1, asynchronous active-low reset.
- io_axi4_0_aw_{valid,id,addr,len,size,burst}, in, {1,ID_W,ADDR_W,8,3,2}, write address channel.
- io_axi4_0_aw_ready, out, 1, write address accept.
- io_axi4_0_w_{valid,data,strb,last}, in, {1,DATA_W,DATA_W/8,1}, write data channel.
- io_axi4_0_w_ready, out, 1, write data accept.
- io_axi4_0_b_ready, in, 1, write response accept.
- io_axi4_0_b_{valid,id,resp}, out, {1,ID_W,2}, write response channel.
- io_axi4_0_ar_{valid,id,addr,len,size,burst}, in, {1,ID_W,ADDR_W,8,3,2}, read address channel.
- io_axi4_0_ar_ready, out, 1, read address accept.
- io_axi4_0_r_ready, in, 1, read data accept.
- io_axi4_0_r_{valid,id,data,resp,last}, out, {1,ID_W,DATA_W,2,1}, read data channel.

Function
REQ-004 Read and write paths SHALL be independent FSMs on a dual-port word memory; both may be active in the same cycle.

REQ-005 Write FSM states SHALL be W_IDLE, W_DATA and W_RESP:
- aw_ready=1 only in W_IDLE.
- w_ready=1 only in W_DATA.
- An AW handshake SHALL move W_IDLE to W_DATA.
- A W handshake with w_last=1 SHALL move W_DATA to W_RESP.
- b_valid=1 in W_RESP; a B handshake SHALL return to W_IDLE.

REQ-006 Each W handshake SHALL write only the byte lanes whose w_strb bit is set; beats after the len+1-th SHALL be accepted but not stored.

REQ-007 Read FSM states SHALL be R_IDLE and R_BURST:
- ar_ready=1 only in R_IDLE.
- The first r_valid SHALL rise exactly 2 cycles after the AR handshake.
- While r_ready is held high, the block SHALL sustain 1 beat per cycle.
- r_last SHALL be 1 on beat len+1.
- The R handshake on r_last SHALL return the FSM to R_IDLE.

REQ-008 Outputs SHALL hold stable while valid is high and ready is low.

REQ-009 Beat address SHALL be generated per burst type, with step = 1<<size:
- FIXED (2'b00): the address is held.
- INCR (2'b01): the address advances by step.
- WRAP (2'b10): the address advances by step and wraps within an aligned block of (len+1)*step bytes.
- Reserved (2'b11): treated as INCR.

REQ-010 The word index SHALL be (addr & ADDR_MASK) >> log2(DATA_W/8), taken modulo DEPTH; sub-word sizes address the full word, and lane selection is the master's strobe/extract duty.

REQ-011 b_id and r_id SHALL equal the ID captured at the corresponding address handshake.

REQ-012 On a same-cycle read/write collision to the same word, the read SHALL return the old data.

Reset
REQ-013 While resetn=0, the block SHALL hold:
- both FSMs in their idle state;
- aw_ready=ar_ready=1;
- w_ready=b_valid=r_valid=r_last=0;
- b_resp=r_resp=2'b00 and b_id=r_id=0.

REQ-014 Memory contents SHALL NOT be reset.

REQ-015 A reset asserted mid-burst SHALL abandon the burst without issuing a response.

Configuration
REQ-016 With AXI_SRAM_MEM_DECERR_EN defined:
- A beat whose masked word index is >= DEPTH SHALL return resp 2'b11 (DECERR).
- Such a read beat SHALL return zero data.
- Such a write beat SHALL be dropped.
- b_resp SHALL be DECERR if any beat of the burst was out of range.

REQ-017 Without AXI_SRAM_MEM_DECERR_EN, indices SHALL wrap modulo DEPTH and every response SHALL be 2'b00 (OKAY).

Structure
REQ-018 Burst-type and resp encodings and the FSM state enums SHALL live in the shared package axi_mem_pkg.

REQ-019 Beat address generation SHALL be one sub-module, axi_burst_addr, instantiated once per channel.

Verification
REQ-020 INCR write: AW addr=0x100, len=3, size=3, strb=0xFF; then INCR read of the same burst -> data words 0x20..0x23 read back, r_last only on the 4th beat, b_resp=0.

REQ-021 WRAP read: addr=0x118, len=3, size=3 -> word order 0x23, 0x20, 0x21, 0x22.

REQ-022 Partial strobe: write 0xFFFF_FFFF_FFFF_FFFF, then write 0 with strb=0x0F; read -> 0xFFFF_FFFF_0000_0000.

REQ-023 Backpressure: toggle r_ready 1/0 during a len=7 read -> no dropped or duplicated beats, and data is stable while stalled.

REQ-024 Range and IDs:
- Address 0x8000_0000 aliases to index 0 via ADDR_MASK.
- With AXI_SRAM_MEM_DECERR_EN and DEPTH=4096, a read at 0x8000 -> r_resp=2'b11 and r_data=0.
- An AW with id=0xA gives b_id=0xA.

REQ-025 Reset: assert resetn=0 at beat 2 of a len=7 read -> r_valid=0 on the next cycle and ar_ready=1 after release.
